mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have the following ports; widths are in bits.
- clk  in  1  single clock
- rstn  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX-stage result valid
- ex_ready  out  1  unit can accept
- ex_memop  in  4  MEM_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW
- ex_alu_c  in  32  ALU result; effective address for memory ops, result otherwise
- ex_rt_data  in  32  store source
- ex_rd  in  5  destination register
- ex_rf_we  in  1  register write requested
- flush  in  1  squash in-flight result
- dm_req  out  1  memory request
- dm_ack  in  1  memory completes the request
- dm_we  out  1  write strobe
- dm_addr  out  32  word address
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-aligned store data
- dm_rdata  in  32  load data, valid with dm_ack
- wb_valid  out  1  one-cycle writeback pulse
- wb_rf_we  out  1  write register file
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- exc_valid  out  1  one-cycle misalignment pulse
- exc_badaddr  out  32  faulting address

Function
REQ-002 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-003 ex_ready SHALL equal (state==IDLE).
REQ-004 When ex_valid and ex_ready are both high at a rising edge, the unit SHALL capture all ex_* inputs.
REQ-005 The next state after a capture SHALL be selected as follows.
- MEM_NONE, or aligned LB/LBU/SB: go to RESP, or to REQ if a memory access is needed.
- LH/LHU/SH with addr[0]=0: go to REQ.
- LW/SW with addr[1:0]=0: go to REQ.
- MEM_NONE always goes to RESP.
REQ-006 A misaligned access SHALL not raise dm_req; it SHALL go to RESP, pulse exc_valid with exc_badaddr equal to the captured address, and hold wb_valid low.
REQ-007 In REQ the unit SHALL drive dm_req=1 and hold dm_we, dm_addr, dm_be and dm_wdata stable until dm_ack.
REQ-008 dm_addr SHALL equal {addr[31:2],2'b00}.
REQ-009 On dm_ack the unit SHALL register dm_rdata and go to RESP; dm_ack outside REQ SHALL be ignored.
REQ-010 Memory accesses SHALL be little-endian with byte lane = addr[1:0].
- SB: be = 1<<addr[1:0]; wdata = rt[7:0] replicated to all four lanes.
- SH: be = 4'b0011 or 4'b1100; wdata = {rt[15:0],rt[15:0]}.
- SW: be = 4'b1111.
- Loads: be reflects the accessed bytes and dm_we=0.
REQ-011 Load extraction SHALL select the lane by addr[1:0].
- LB/LH sign-extend to 32 bits.
- LBU/LHU zero-extend to 32 bits.
- LW passes the word through.
REQ-012 RESP SHALL last exactly one cycle and always return to IDLE.
- wb_valid=1 unless the access faulted or was flushed.
- wb_data = ex_alu_c for MEM_NONE, the extended load data for loads.
- wb_rf_we = captured ex_rf_we AND not a store.
REQ-013 Minimum latency SHALL be as follows (capture at edge 0).
- MEM_NONE and misaligned accesses: response in cycle 1.
- Memory op with dm_ack in its first REQ cycle: wb_valid in cycle 2.
REQ-014 flush asserted in REQ or RESP SHALL suppress the pending wb_valid and exc_valid.
- A memory request already issued SHALL complete its handshake; dm_req SHALL not drop before dm_ack.
REQ-015 flush in IDLE SHALL block capture in that cycle.
REQ-016 wb_rd SHALL equal the captured ex_rd; wb_* values outside wb_valid are don't-care but SHALL not be X after reset.

Reset
REQ-017 When rstn=0, the unit SHALL asynchronously enter IDLE and drive the following outputs.
- dm_req, dm_we, wb_valid, wb_rf_we, exc_valid: 0
- dm_addr, dm_be, dm_wdata, wb_rd, wb_data, exc_badaddr: 0
REQ-018 Reset asserted in REQ SHALL abandon the request with no further dm_req and no writeback.

Structure
REQ-019 The MEM_* op encodings SHALL be `defines in the shared ctrl_encode_def.v, beside the ALU_* codes.
REQ-020 Load lane selection and extension SHALL be a combinational sub-module mem_ld_ext (inputs: op, addr[1:0], rdata; output: 32-bit data).
REQ-021 The implementation SHALL be 120-400 RTL lines and SHALL have no latches.

Verification
REQ-022 LB at addr 0x1003, dm_rdata=0x80FF_1234, ack in first REQ cycle -> wb_data=0xFFFF_FF80 at cycle 2, dm_be=4'b1000.
REQ-023 SH at addr 0x2002, rt=0x0000_ABCD -> dm_be=4'b1100, dm_wdata=0xABCD_ABCD, dm_we=1; with ack delayed 3 cycles, request signals are stable, wb_valid=1, wb_rf_we=0.
REQ-024 LW at addr 0x0006 -> no dm_req, exc_valid=1 at cycle 1 with exc_badaddr=0x0000_0006, wb_valid=0.
REQ-025 MEM_NONE, ex_alu_c=0x1234_5678, rd=9, rf_we=1 -> wb_valid at cycle 1 with wb_data=0x1234_5678, wb_rd=9; ex_ready low for one cycle.
REQ-026 LHU at addr 0x10, flush raised while waiting for dm_ack -> dm_req is held until ack, no wb_valid, then IDLE with ex_ready=1.
REQ-027 rstn pulsed low mid-REQ (asynchronously, between clock edges) -> dm_req=0 immediately, all outputs 0, and no wb_valid after reset release.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared encodings and helpers for the memory access stage.
// Holds the MEM_* operation codes, with the ALU_* codes beside them, the FSM
// state constants, and small pure functions for op classification, alignment,
// byte-enable generation and store-lane replication.
// No ports (package).

`ifndef CTRL_ENCODE_DEF
`define CTRL_ENCODE_DEF
`define ALU_NOP   4'd0
`define ALU_ADD   4'd1
`define ALU_SUB   4'd2
`define ALU_AND   4'd3
`define ALU_OR    4'd4
`define MEM_NONE  4'd0
`define MEM_LB    4'd1
`define MEM_LBU   4'd2
`define MEM_LH    4'd3
`define MEM_LHU   4'd4
`define MEM_LW    4'd5
`define MEM_SB    4'd6
`define MEM_SH    4'd7
`define MEM_SW    4'd8
`endif

package mem_access_unit_pkg;

  localparam logic [3:0] MEM_NONE = `MEM_NONE;
  localparam logic [3:0] MEM_LB   = `MEM_LB;
  localparam logic [3:0] MEM_LBU  = `MEM_LBU;
  localparam logic [3:0] MEM_LH   = `MEM_LH;
  localparam logic [3:0] MEM_LHU  = `MEM_LHU;
  localparam logic [3:0] MEM_LW   = `MEM_LW;
  localparam logic [3:0] MEM_SB   = `MEM_SB;
  localparam logic [3:0] MEM_SH   = `MEM_SH;
  localparam logic [3:0] MEM_SW   = `MEM_SW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  // Halfword ops need bit 0 clear, word ops need both low bits clear;
  // byte ops and non-memory ops can never fault.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: bad = lane[0];
      MEM_LW, MEM_SW:          bad = (lane != 2'b00);
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [3:0] op, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: be = 4'b0001 << lane;
      MEM_LH, MEM_LHU, MEM_SH: be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_LW, MEM_SW:          be = 4'b1111;
      default:                 be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick
  // which bytes the memory actually writes.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] rt);
    logic [31:0] wd;
    wd = 32'h0;
    case (op)
      MEM_SB:  wd = {4{rt[7:0]}};
      MEM_SH:  wd = {2{rt[15:0]}};
      MEM_SW:  wd = rt;
      default: wd = 32'h0;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_access_unit_ld_ext.sv
// mem_ld_ext
// Combinational load lane selection and sign/zero extension.
// Ports:
//   op    in  4   MEM_* load code
//   addr  in  2   byte lane (address bits [1:0])
//   rdata in  32  raw little-endian memory word
//   data  out 32  extended load result (0 for non-load ops)

module mem_ld_ext
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    data     = 32'h0;
    case (op)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'h0, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data = {16'h0, half_sel};
      MEM_LW:  data = rdata;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM pipeline stage: takes one EX result at a time, performs an optional
// little-endian data-memory access with a req/ack handshake, and produces a
// one-cycle writeback pulse or a one-cycle misalignment exception pulse.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   ex_valid/ex_ready         EX handshake; ex_ready is high only in IDLE
//   ex_memop, ex_alu_c,
//   ex_rt_data, ex_rd,
//   ex_rf_we                  captured EX result fields
//   flush                     squashes the in-flight result
//   dm_req/dm_ack             memory handshake; dm_we, dm_addr, dm_be,
//                             dm_wdata held while dm_req is high
//   dm_rdata                  load data, valid with dm_ack
//   wb_valid, wb_rf_we,
//   wb_rd, wb_data            writeback pulse and payload
//   exc_valid, exc_badaddr    misalignment pulse and faulting address

module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_alu_c,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rf_we,
  input  logic        flush,
  output logic        dm_req,
  input  logic        dm_ack,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [31:0] exc_badaddr
);

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic        rf_we_q;
  logic        fault_q;
  logic        flushed_q;
  logic [31:0] ld_data;
  logic        capture;
  logic        cap_fault;
  logic        cap_mem;

  // A flush in IDLE blocks capture even though ex_ready stays high.
  assign capture   = ex_valid && (state == ST_IDLE) && !flush;
  assign cap_fault = is_misaligned(ex_memop, ex_alu_c[1:0]);
  assign cap_mem   = (is_load(ex_memop) || is_store(ex_memop)) && !cap_fault;

  mem_ld_ext u_ld_ext (
    .op    (op_q),
    .addr  (addr_q[1:0]),
    .rdata (dm_rdata),
    .data  (ld_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      op_q      <= MEM_NONE;
      addr_q    <= 32'h0;
      rd_q      <= 5'd0;
      rf_we_q   <= 1'b0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= 32'h0;
      dm_be     <= 4'b0000;
      dm_wdata  <= 32'h0;
      wb_data   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            op_q      <= ex_memop;
            addr_q    <= ex_alu_c;
            rd_q      <= ex_rd;
            rf_we_q   <= ex_rf_we;
            fault_q   <= cap_fault;
            flushed_q <= 1'b0;
            // Preloaded with the ALU result; a load overwrites it on dm_ack.
            wb_data   <= ex_alu_c;
            if (cap_mem) begin
              dm_we    <= is_store(ex_memop);
              dm_addr  <= {ex_alu_c[31:2], 2'b00};
              dm_be    <= byte_enable(ex_memop, ex_alu_c[1:0]);
              dm_wdata <= store_data(ex_memop, ex_rt_data);
              state    <= ST_REQ;
            end else begin
              state    <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          // A flush here only marks the result dead; the handshake itself
          // must still complete so the memory is never left mid-request.
          if (flush) begin
            flushed_q <= 1'b1;
          end
          if (dm_ack) begin
            if (is_load(op_q)) begin
              wb_data <= ld_data;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response pulses are gated by the live flush too, so a flush arriving
  // during RESP itself still suppresses them.
  always_comb begin
    ex_ready    = (state == ST_IDLE);
    dm_req      = (state == ST_REQ);
    wb_valid    = (state == ST_RESP) && !fault_q && !flushed_q && !flush;
    exc_valid   = (state == ST_RESP) && fault_q && !flushed_q && !flush;
    wb_rf_we    = wb_valid && rf_we_q && !is_store(op_q);
    wb_rd       = rd_q;
    exc_badaddr = addr_q;
  end

endmodule
